// File: rtl/sysbus_arbiter.sv
// Sysbus arbiter: shares one line-transaction channel between fetch (F) and data (D).
// Each grant runs one address phase, then 8 write beats or 8 routed read-response beats.
module sysbus_arbiter #(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned TAG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_resp_valid,
  output logic [ADDR_W-1:0] f_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_wdata,
  output logic              d_wdata_ready,
  output logic              d_resp_valid,
  output logic [ADDR_W-1:0] d_resp_data,
  output logic              bus_reqcyc,
  output logic [ADDR_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [ADDR_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack
);

  localparam int unsigned       CNT_W     = $clog2(BEATS);
  localparam logic [3:0]        MEMORY    = 4'b0001;
  localparam logic              DIR_READ  = 1'b1;
  localparam logic              DIR_WRITE = 1'b0;
  localparam logic [7:0]        ID_F      = 8'h00;
  localparam logic [7:0]        ID_D      = 8'h01;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RESP} state_t;
  typedef enum logic {OWN_F, OWN_D} owner_t;

  state_t             r_state;
  owner_t             r_owner;
  owner_t             r_last_grant;
  logic               r_is_write;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [TAG_W-1:0]   r_tag;

  logic               w_active;
  logic               w_grant_f;
  logic               w_grant_d;
  logic               w_in_req;
  logic               w_in_resp;
  logic               w_hit;
  logic               w_last_beat;
  logic [7:0]         w_owner_id;

  // Grant decode and bus/requester muxing; everything is held quiet while reset is high.
  always_comb begin
    w_active      = !reset;
    w_owner_id    = (r_owner == OWN_D) ? ID_D : ID_F;
    w_last_beat   = (r_cnt == CNT_W'(BEATS - 1));
    w_grant_f     = w_active && (r_state == S_IDLE) && f_req_valid &&
                    (!d_req_valid || (r_last_grant == OWN_D));
    w_grant_d     = w_active && (r_state == S_IDLE) && d_req_valid && !w_grant_f;
    w_in_req      = w_active && ((r_state == S_ADDR) || (r_state == S_WDATA));
    w_in_resp     = w_active && (r_state == S_RESP) && bus_respcyc;
    w_hit         = w_in_resp && (bus_resptag[7:0] == w_owner_id);

    f_req_ready   = w_grant_f;
    d_req_ready   = w_grant_d;
    bus_reqcyc    = w_in_req;
    bus_reqtag    = w_in_req ? r_tag : '0;
    bus_req       = '0;
    if (w_in_req) begin
      bus_req = (r_state == S_WDATA) ? d_wdata : r_addr;
    end
    d_wdata_ready = w_in_req && (r_state == S_WDATA) && bus_reqack;
    bus_respack   = w_in_resp;
    f_resp_valid  = w_hit && (r_owner == OWN_F);
    f_resp_data   = f_resp_valid ? bus_resp : '0;
    d_resp_valid  = w_hit && (r_owner == OWN_D);
    d_resp_data   = d_resp_valid ? bus_resp : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_F;
      r_last_grant <= OWN_D;
      r_is_write   <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_tag        <= '0;
    end else begin
      assert (!(bus_respcyc && (r_state != S_RESP)))
        else $warning("sysbus_arbiter: response beat outside RESP, tag %h", bus_resptag);
      assert (!(w_in_resp && !w_hit))
        else $warning("sysbus_arbiter: stray response tag %h dropped", bus_resptag);

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_f) begin
            r_owner      <= OWN_F;
            r_is_write   <= 1'b0;
            r_addr       <= f_req_addr & LINE_MASK;
            r_tag        <= TAG_W'({DIR_READ, MEMORY, ID_F});
            r_last_grant <= OWN_F;
            r_state      <= S_ADDR;
          end else if (w_grant_d) begin
            r_owner      <= OWN_D;
            r_is_write   <= d_req_write;
            r_addr       <= d_req_addr & LINE_MASK;
            r_tag        <= TAG_W'({d_req_write ? DIR_WRITE : DIR_READ, MEMORY, ID_D});
            r_last_grant <= OWN_D;
            r_state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_reqack) begin
            r_cnt   <= '0;
            r_state <= r_is_write ? S_WDATA : S_RESP;
          end
        end
        S_WDATA: begin
          if (bus_reqack) begin
            if (w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_RESP: begin
          // Only beats carrying the owner's id advance the burst.
          if (w_hit) begin
            if (w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
